mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Single-port memory bus arbiter. Shares one external SRAM/bus slave between the instruction-fetch requester (PC/IF stage) and the data requester (MEM stage load/store).
- Sequences each transaction with a req/ack handshake.
- Raises a pipeline stall request while any requester is waiting.
- Sits between the pipeline core and the memory wrapper, replacing separate ROM/RAM ports.

Parameters:
- ADDR_W, 32, address width of requesters and bus
- DATA_W, 32, data width (`RegBus)
- TIMEOUT_CYCLES, 255, max cycles a granted transaction may wait for bus_ack_i (used only with BUS_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i high
- if_ack_o  out  1  fetch complete, 1-cycle pulse
- if_rdata_o  out  DATA_W  fetched instruction, valid when if_ack_o
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_sel_i  in  4  byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_ack_o  out  1  data complete, 1-cycle pulse
- dm_rdata_o  out  DATA_W  load data, valid when dm_ack_o
- bus_req_o  out  1  bus transaction active
- bus_we_o  out  1  bus write strobe
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_ack_i  in  1  slave completion, 1-cycle pulse
- bus_rdata_i  in  DATA_W  slave read data, valid with bus_ack_i
- stallreq_o  out  1  pipeline stall request
- bus_err_o  out  1  timeout error pulse (tied 0 without macro)

Behaviour:
- Reset (rst=0, async): state=IDLE. All bus_* outputs 0. if_ack_o=0, dm_ack_o=0, rdata outputs 0. Timeout counter 0, bus_err_o=0. An in-flight transaction is abandoned; any late bus_ack_i after release is ignored.
- States: IDLE, IF_BUSY, DM_BUSY.
- Transitions out of IDLE:
  - dm_req_i=1 → DM_BUSY. Data has fixed priority over fetch (MEM stage is older).
  - else if_req_i=1 → IF_BUSY.
  - else stay IDLE.
- On entering a BUSY state, bus_req_o/bus_we_o/bus_sel_o/bus_addr_o/bus_wdata_o are registered from the winner's inputs. They stay constant until completion. For fetch: bus_we_o=0, bus_sel_o=4'b1111, bus_wdata_o=0.
- In BUSY state with bus_ack_i=1 (same cycle, combinational):
  - winner's ack_o=1 and rdata_o=bus_rdata_i, both only while the winner's req_i is still high; otherwise the ack is dropped.
  - Next edge: state=IDLE, bus_req_o=0.
- Minimum latency: req at cycle N → bus_req_o high N+1 → ack at N+1 earliest → IDLE at N+2. There is one mandatory idle cycle between transactions, so max throughput is one access per 2 cycles.
- bus_ack_i while IDLE is ignored.
- Simultaneous if_req_i and dm_req_i: data is served first. Fetch is granted from the IDLE cycle that follows.
- stallreq_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o). Combinational; 0 in reset.
- Requester dropping req mid-transaction: the bus transaction still completes and the ack is not forwarded.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - Counter of width clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle without bus_ack_i.
  - When the count reaches TIMEOUT_CYCLES, the winner gets ack_o=1 with rdata_o=32'hDEAD_BEEF, bus_err_o pulses 1 for one cycle, and state returns to IDLE.
  - bus_ack_i in the same cycle as the timeout takes precedence: normal completion, no error.
- Undefined: no counter; bus_err_o tied 0; the arbiter waits indefinitely.

Test Plan:
- Reset → all outputs 0. Release, if_req_i=1, addr 0x0000_0004, slave acks in the next cycle with 0x3401_1100 → bus_addr_o=0x4 at N+1, if_ack_o=1 and if_rdata_o=0x3401_1100 at N+1, stallreq_o high only at N.
- if_req_i and dm_req_i rise together (store, addr 0x100, wdata 0xABCD_0123, sel 4'b1111) → first bus transaction has bus_we_o=1, addr 0x100; fetch is granted 2 cycles after the data ack; stallreq_o stays high until if_ack_o.
- Slave delays ack 5 cycles on a load of addr 0x200 → bus outputs stable for 5 cycles, dm_ack_o single pulse, stallreq_o high for 6 cycles.
- Assert rst mid-DM_BUSY, then ack arrives after release → bus_req_o drops immediately; the stray ack produces no dm_ack_o/if_ack_o.
- Fetch requester drops if_req_i before ack → if_ack_o never asserts; state returns to IDLE after bus_ack_i.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → after 8 busy cycles dm_ack_o=1, dm_rdata_o=0xDEAD_BEEF, bus_err_o 1-cycle pulse, bus_req_o drops.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester, bus-slave and status signals of the single-port memory arbiter.
// slave: arbiter side; master: pipeline core plus memory wrapper side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [3:0]        dm_sel_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    logic              stallreq_o;
    logic              bus_err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_ack_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        output dm_ack_o, dm_rdata_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i,
        output stallreq_o, bus_err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_ack_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        input  dm_ack_o, dm_rdata_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i,
        input  stallreq_o, bus_err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one bus slave between fetch and data requesters, data first.
// Optional BUS_TIMEOUT_EN: abort a stalled transfer after TIMEOUT_CYCLES.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave mb
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_e;

    state_e            state_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [3:0]        bus_sel_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;

    logic              timeout;
    logic              done;
    logic [DATA_W-1:0] rsp_data;
    logic              if_hit;
    logic              dm_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign timeout = (state_q != IDLE) && !mb.bus_ack_i &&
                     (cnt_q == CW'(TIMEOUT_CYCLES));
    assign rsp_data = timeout ? DATA_W'(32'hDEAD_BEEF) : mb.bus_rdata_i;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (!done)      cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign timeout  = 1'b0;
    assign rsp_data = mb.bus_rdata_i;
`endif

    assign done   = mb.bus_ack_i | timeout;
    assign if_hit = (state_q == IF_BUSY) & done & mb.if_req_i;
    assign dm_hit = (state_q == DM_BUSY) & done & mb.dm_req_i;

    assign mb.if_ack_o    = if_hit;
    assign mb.if_rdata_o  = if_hit ? rsp_data : '0;
    assign mb.dm_ack_o    = dm_hit;
    assign mb.dm_rdata_o  = dm_hit ? rsp_data : '0;
    assign mb.bus_err_o   = timeout;
    assign mb.bus_req_o   = bus_req_q;
    assign mb.bus_we_o    = bus_we_q;
    assign mb.bus_sel_o   = bus_sel_q;
    assign mb.bus_addr_o  = bus_addr_q;
    assign mb.bus_wdata_o = bus_wdata_q;

    // Gated by rst so the stall drops as soon as reset asserts.
    assign mb.stallreq_o = rst & ((mb.if_req_i & ~if_hit) |
                                  (mb.dm_req_i & ~dm_hit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mb.dm_req_i) begin
                        state_q     <= DM_BUSY;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mb.dm_we_i;
                        bus_sel_q   <= mb.dm_sel_i;
                        bus_addr_q  <= mb.dm_addr_i;
                        bus_wdata_q <= mb.dm_wdata_i;
                    end else if (mb.if_req_i) begin
                        state_q     <= IF_BUSY;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_sel_q   <= 4'b1111;
                        bus_addr_q  <= mb.if_addr_i;
                        bus_wdata_q <= '0;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (done) begin
                        state_q     <= IDLE;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_sel_q   <= '0;
                        bus_addr_q  <= '0;
                        bus_wdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, corner sequences, random vs model.
// Timeout sequence is built only with BUS_TIMEOUT_EN (TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .mb(mb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_breq;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iack;
    logic        e_dack;
    logic        e_stall;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tv[18];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mb.if_req_i = v.if_req;
    mb.if_addr_i = v.if_addr;
    mb.dm_req_i = v.dm_req;
    mb.dm_we_i = v.dm_we;
    mb.dm_sel_i = v.dm_sel;
    mb.dm_addr_i = v.dm_addr;
    mb.dm_wdata_i = v.dm_wdata;
    mb.bus_ack_i = v.ack;
    mb.bus_rdata_i = v.rdata;
  endtask

  task automatic idle_inputs();
    mb.if_req_i = 0; mb.if_addr_i = 0;
    mb.dm_req_i = 0; mb.dm_we_i = 0; mb.dm_sel_i = 0;
    mb.dm_addr_i = 0; mb.dm_wdata_i = 0;
    mb.bus_ack_i = 0; mb.bus_rdata_i = 0;
  endtask

  // Transaction-level reference: one grant record at a time.
  logic        g_valid;
  logic        g_dm;
  logic        g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;

  task automatic model_check(input int cyc);
    logic ei, ed;
    ei = g_valid && !g_dm && mb.bus_ack_i && mb.if_req_i;
    ed = g_valid && g_dm && mb.bus_ack_i && mb.dm_req_i;
    check($sformatf("r%0d bus_req", cyc), 32'(mb.bus_req_o), 32'(g_valid));
    if (g_valid) begin
      check($sformatf("r%0d bus_we", cyc), 32'(mb.bus_we_o), 32'(g_we));
      check($sformatf("r%0d bus_sel", cyc), 32'(mb.bus_sel_o), 32'(g_sel));
      check($sformatf("r%0d bus_addr", cyc), mb.bus_addr_o, g_addr);
      check($sformatf("r%0d bus_wdata", cyc), mb.bus_wdata_o, g_wdata);
    end
    check($sformatf("r%0d if_ack", cyc), 32'(mb.if_ack_o), 32'(ei));
    check($sformatf("r%0d dm_ack", cyc), 32'(mb.dm_ack_o), 32'(ed));
    if (ei) check($sformatf("r%0d if_rdata", cyc), mb.if_rdata_o,
                  mb.bus_rdata_i);
    if (ed) check($sformatf("r%0d dm_rdata", cyc), mb.dm_rdata_o,
                  mb.bus_rdata_i);
    check($sformatf("r%0d stall", cyc), 32'(mb.stallreq_o),
          32'((mb.if_req_i && !ei) || (mb.dm_req_i && !ed)));
    check($sformatf("r%0d bus_err", cyc), 32'(mb.bus_err_o), 0);
    if (g_valid) begin
      if (mb.bus_ack_i) g_valid = 0;
    end else if (mb.dm_req_i) begin
      g_valid = 1; g_dm = 1; g_we = mb.dm_we_i; g_sel = mb.dm_sel_i;
      g_addr = mb.dm_addr_i; g_wdata = mb.dm_wdata_i;
    end else if (mb.if_req_i) begin
      g_valid = 1; g_dm = 0; g_we = 0; g_sel = 4'hF;
      g_addr = mb.if_addr_i; g_wdata = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic li, ld;
    int wcnt;

    tv[0]  = '{1, 32'h4, 0, 0, 4'h0, 0, 0, 0, 0,
               0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    tv[1]  = '{1, 32'h4, 0, 0, 4'h0, 0, 0, 1, 32'h3401_1100,
               1, 0, 4'hF, 32'h4, 0, 1, 0, 0, 32'h3401_1100};
    tv[2]  = '{0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
               0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 32'h8, 1, 1, 4'hF, 32'h100, 32'hABCD_0123, 0, 0,
               0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    tv[4]  = '{1, 32'h8, 1, 1, 4'hF, 32'h100, 32'hABCD_0123, 0, 0,
               1, 1, 4'hF, 32'h100, 32'hABCD_0123, 0, 0, 1, 0};
    tv[5]  = '{1, 32'h8, 1, 1, 4'hF, 32'h100, 32'hABCD_0123,
               1, 32'h1111_2222,
               1, 1, 4'hF, 32'h100, 32'hABCD_0123, 0, 1, 1, 32'h1111_2222};
    tv[6]  = '{1, 32'h8, 0, 0, 4'h0, 0, 0, 0, 0,
               0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    tv[7]  = '{1, 32'h8, 0, 0, 4'h0, 0, 0, 0, 0,
               1, 0, 4'hF, 32'h8, 0, 0, 0, 1, 0};
    tv[8]  = '{1, 32'h8, 0, 0, 4'h0, 0, 0, 1, 32'h55,
               1, 0, 4'hF, 32'h8, 0, 1, 0, 0, 32'h55};
    tv[9]  = '{0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h77,
               0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    tv[10] = '{0, 0, 1, 0, 4'h3, 32'h200, 0, 0, 0,
               0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    for (int i = 11; i < 16; i++)
      tv[i] = '{0, 0, 1, 0, 4'h3, 32'h200, 0, 0, 0,
                1, 0, 4'h3, 32'h200, 0, 0, 0, 1, 0};
    tv[16] = '{0, 0, 1, 0, 4'h3, 32'h200, 0, 1, 32'hCAFE,
               1, 0, 4'h3, 32'h200, 0, 0, 1, 0, 32'hCAFE};
    tv[17] = '{0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
               0, 0, 4'h0, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    mb.if_req_i = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst bus_req", 32'(mb.bus_req_o), 0);
    check("rst bus_we", 32'(mb.bus_we_o), 0);
    check("rst bus_sel", 32'(mb.bus_sel_o), 0);
    check("rst bus_addr", mb.bus_addr_o, 0);
    check("rst bus_wdata", mb.bus_wdata_o, 0);
    check("rst if_ack", 32'(mb.if_ack_o), 0);
    check("rst dm_ack", 32'(mb.dm_ack_o), 0);
    check("rst if_rdata", mb.if_rdata_o, 0);
    check("rst dm_rdata", mb.dm_rdata_o, 0);
    check("rst stall", 32'(mb.stallreq_o), 0);
    check("rst bus_err", 32'(mb.bus_err_o), 0);
    @(negedge clk);
    idle_inputs();
    rst = 1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check($sformatf("tv%0d bus_req", i), 32'(mb.bus_req_o),
            32'(tv[i].e_breq));
      if (tv[i].e_breq) begin
        check($sformatf("tv%0d bus_we", i), 32'(mb.bus_we_o),
              32'(tv[i].e_we));
        check($sformatf("tv%0d bus_sel", i), 32'(mb.bus_sel_o),
              32'(tv[i].e_sel));
        check($sformatf("tv%0d bus_addr", i), mb.bus_addr_o, tv[i].e_addr);
        check($sformatf("tv%0d bus_wdata", i), mb.bus_wdata_o,
              tv[i].e_wdata);
      end
      check($sformatf("tv%0d if_ack", i), 32'(mb.if_ack_o),
            32'(tv[i].e_iack));
      check($sformatf("tv%0d dm_ack", i), 32'(mb.dm_ack_o),
            32'(tv[i].e_dack));
      check($sformatf("tv%0d stall", i), 32'(mb.stallreq_o),
            32'(tv[i].e_stall));
      if (tv[i].e_iack)
        check($sformatf("tv%0d if_rdata", i), mb.if_rdata_o, tv[i].e_rdata);
      if (tv[i].e_dack)
        check($sformatf("tv%0d dm_rdata", i), mb.dm_rdata_o, tv[i].e_rdata);
      check($sformatf("tv%0d bus_err", i), 32'(mb.bus_err_o), 0);
    end

    // Reset during a data transfer, then a stray ack.
    @(negedge clk);
    idle_inputs();
    mb.dm_req_i = 1; mb.dm_sel_i = 4'hF; mb.dm_addr_i = 32'h300;
    @(negedge clk);
    #1;
    check("mid_rst busy", 32'(mb.bus_req_o), 1);
    rst = 0;
    #1;
    check("mid_rst bus_req", 32'(mb.bus_req_o), 0);
    check("mid_rst stall", 32'(mb.stallreq_o), 0);
    mb.dm_req_i = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    mb.bus_ack_i = 1; mb.bus_rdata_i = 32'h1234;
    #1;
    check("stray dm_ack", 32'(mb.dm_ack_o), 0);
    check("stray if_ack", 32'(mb.if_ack_o), 0);
    check("stray bus_req", 32'(mb.bus_req_o), 0);

    // Fetch requester withdraws before the slave answers.
    @(negedge clk);
    idle_inputs();
    mb.if_req_i = 1; mb.if_addr_i = 32'h40;
    @(negedge clk);
    #1;
    check("drop bus_req", 32'(mb.bus_req_o), 1);
    check("drop bus_addr", mb.bus_addr_o, 32'h40);
    mb.if_req_i = 0;
    #1;
    check("drop stall", 32'(mb.stallreq_o), 0);
    @(negedge clk);
    mb.bus_ack_i = 1; mb.bus_rdata_i = 32'h9999;
    #1;
    check("drop if_ack", 32'(mb.if_ack_o), 0);
    check("drop still_busy", 32'(mb.bus_req_o), 1);
    @(negedge clk);
    mb.bus_ack_i = 0;
    #1;
    check("drop idle", 32'(mb.bus_req_o), 0);

`ifdef BUS_TIMEOUT_EN
    begin
      int busy;
      logic got;
      busy = 0; got = 0;
      @(negedge clk);
      idle_inputs();
      mb.dm_req_i = 1; mb.dm_sel_i = 4'hF; mb.dm_addr_i = 32'h400;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        #1;
        if (mb.dm_ack_o) got = 1;
        else if (mb.bus_req_o) busy++;
      end
      check("to ack", 32'(got), 1);
      check("to busy_cycles", busy, 8);
      check("to rdata", mb.dm_rdata_o, 32'hDEAD_BEEF);
      check("to err", 32'(mb.bus_err_o), 1);
      check("to still_req", 32'(mb.bus_req_o), 1);
      @(negedge clk);
      mb.dm_req_i = 0;
      #1;
      check("to bus_req_drop", 32'(mb.bus_req_o), 0);
      check("to err_pulse", 32'(mb.bus_err_o), 0);
    end
`endif

    // Random traffic against the transaction-level model.
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    g_valid = 0; g_dm = 0; g_we = 0; g_sel = 0; g_addr = 0; g_wdata = 0;
    li = 0; ld = 0; wcnt = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (li || (mb.if_req_i && $urandom_range(31) == 0)) mb.if_req_i = 0;
      else if (!mb.if_req_i && $urandom_range(2) == 0) begin
        mb.if_req_i = 1;
        mb.if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (ld || (mb.dm_req_i && $urandom_range(31) == 0)) mb.dm_req_i = 0;
      else if (!mb.dm_req_i && $urandom_range(2) == 0) begin
        mb.dm_req_i = 1;
        mb.dm_we_i = 1'($urandom);
        mb.dm_sel_i = 4'($urandom);
        mb.dm_addr_i = $urandom;
        mb.dm_wdata_i = $urandom;
      end
      if (mb.bus_req_o)
        mb.bus_ack_i = (wcnt >= 5) || ($urandom_range(2) == 0);
      else
        mb.bus_ack_i = ($urandom_range(7) == 0);
      mb.bus_rdata_i = $urandom;
      wcnt = (mb.bus_req_o && !mb.bus_ack_i) ? wcnt + 1 : 0;
      #1;
      li = mb.if_ack_o;
      ld = mb.dm_ack_o;
      model_check(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
